// File: rtl/rx_crc_frame_buffer_if.sv
// rtl/rx_crc_frame_buffer_if.sv - stream and status bundle for the CRC frame buffer.
// out_crc_err exists only when RX_ERR_FORWARD_EN is defined.
interface rx_crc_frame_buffer_if #(
    parameter int HADAMARD   = 4,
    parameter int BIT_NUM    = 4,
    parameter int CRC_BITS   = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_BITS   = 16
);
    localparam int PAYLOAD_BITS = HADAMARD * BIT_NUM;
    localparam int FRAME_BITS   = PAYLOAD_BITS + CRC_BITS;
    localparam int LVL_BITS     = $clog2(FIFO_DEPTH + 1);

    logic [FRAME_BITS-1:0]   in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [PAYLOAD_BITS-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [LVL_BITS-1:0]     fifo_level;
    logic [CNT_BITS-1:0]     frame_cnt;
    logic [CNT_BITS-1:0]     err_cnt;
    logic                    err_pulse;
`ifdef RX_ERR_FORWARD_EN
    logic                    out_crc_err;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, fifo_level, frame_cnt, err_cnt, err_pulse, out_crc_err
    );
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, fifo_level, frame_cnt, err_cnt, err_pulse, out_crc_err
    );
`else
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, fifo_level, frame_cnt, err_cnt, err_pulse
    );
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, fifo_level, frame_cnt, err_cnt, err_pulse
    );
`endif
endinterface

// File: rtl/rx_crc_frame_buffer.sv
// rtl/rx_crc_frame_buffer.sv - CRC check of received chip frames feeding a payload FIFO.
// Optional RX_ERR_FORWARD_EN: bad frames are queued with a flag instead of dropped.
module rx_crc_frame_buffer #(
    parameter int                 HADAMARD   = 4,
    parameter int                 BIT_NUM    = 4,
    parameter int                 CRC_BITS   = 4,
    parameter logic [CRC_BITS-1:0] CRC_POLY  = 4'h3,
    parameter int                 FIFO_DEPTH = 4,
    parameter int                 CNT_BITS   = 16
) (
    input logic                   clk,
    input logic                   reset,
    rx_crc_frame_buffer_if.slave  bus
);
    localparam int PAYLOAD_BITS = HADAMARD * BIT_NUM;
    localparam int FRAME_BITS   = PAYLOAD_BITS + CRC_BITS;
    localparam int LVL_BITS     = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_BITS     = $clog2(FIFO_DEPTH);
`ifdef RX_ERR_FORWARD_EN
    localparam int ENTRY_BITS   = PAYLOAD_BITS + 1;
`else
    localparam int ENTRY_BITS   = PAYLOAD_BITS;
`endif

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WAIT} state_t;

    function automatic logic [CRC_BITS-1:0] crc_calc(input logic [PAYLOAD_BITS-1:0] p);
        logic [CRC_BITS-1:0] c;
        logic                fb;
        c = '0;
        for (int i = PAYLOAD_BITS - 1; i >= 0; i--) begin
            fb = c[CRC_BITS-1] ^ p[i];
            c  = {c[CRC_BITS-2:0], 1'b0};
            if (fb) c = c ^ CRC_POLY;
        end
        return c;
    endfunction

    function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
        return (p == PTR_BITS'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    state_t                  r_state;
    state_t                  w_next;
    logic [FRAME_BITS-1:0]   r_frame;
    logic [ENTRY_BITS-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_BITS-1:0]     r_wr_ptr;
    logic [PTR_BITS-1:0]     r_rd_ptr;
    logic [LVL_BITS-1:0]     r_level;
    logic [CNT_BITS-1:0]     r_frame_cnt;
    logic [CNT_BITS-1:0]     r_err_cnt;
    logic                    r_err_pulse;

    logic [PAYLOAD_BITS-1:0] w_payload;
    logic                    w_crc_ok;
    logic                    w_has_room;
    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_crc_fail;
    logic [ENTRY_BITS-1:0]   w_entry;
    logic                    w_out_valid;

    assign w_payload   = r_frame[FRAME_BITS-1:CRC_BITS];
    assign w_crc_ok    = (crc_calc(w_payload) == r_frame[CRC_BITS-1:0]);
    // Room is judged on the start-of-cycle level, so a same-cycle pop never frees a slot.
    assign w_has_room  = (r_level < LVL_BITS'(FIFO_DEPTH));
    assign w_out_valid = (r_level != '0);
    assign w_pop       = w_out_valid && bus.out_ready;
`ifdef RX_ERR_FORWARD_EN
    assign w_entry     = {~w_crc_ok, w_payload};
`else
    assign w_entry     = w_payload;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_accept   = 1'b0;
        w_push     = 1'b0;
        w_crc_fail = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_CHECK;
                end
            end
            S_CHECK: begin
                w_crc_fail = ~w_crc_ok;
`ifdef RX_ERR_FORWARD_EN
                if (w_has_room) begin
                    w_push = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    w_next = S_WAIT;
                end
`else
                if (!w_crc_ok) begin
                    w_next = S_IDLE;
                end else if (w_has_room) begin
                    w_push = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    w_next = S_WAIT;
                end
`endif
            end
            S_WAIT: begin
                if (w_has_room) begin
                    w_push = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
            r_err_pulse <= 1'b0;
        end else begin
            if (w_accept) begin
                r_frame <= bus.in_data;
                if (r_frame_cnt != '1) r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            r_err_pulse <= w_crc_fail;
            if (w_crc_fail && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_BITS'(1);
                2'b01:   r_level <= r_level - LVL_BITS'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: the level/pointers decide what is visible.
    always_ff @(posedge clk) begin
        if (w_push && !reset) r_mem[r_wr_ptr] <= w_entry;
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_data   = w_out_valid ? r_mem[r_rd_ptr][PAYLOAD_BITS-1:0] : '0;
    assign bus.fifo_level = r_level;
    assign bus.frame_cnt  = r_frame_cnt;
    assign bus.err_cnt    = r_err_cnt;
    assign bus.err_pulse  = r_err_pulse;
`ifdef RX_ERR_FORWARD_EN
    assign bus.out_crc_err = w_out_valid ? r_mem[r_rd_ptr][PAYLOAD_BITS] : 1'b0;
`endif
endmodule

// File: tb/tb_rx_crc_frame_buffer.sv
// tb/tb_rx_crc_frame_buffer.sv - scoreboard bench for rx_crc_frame_buffer (RX_ERR_FORWARD_EN aware).
module tb_rx_crc_frame_buffer;
`ifdef RX_ERR_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rx_crc_frame_buffer_if #(.HADAMARD(4), .BIT_NUM(4), .CRC_BITS(4), .FIFO_DEPTH(4), .CNT_BITS(16)) bus ();

    rx_crc_frame_buffer #(
        .HADAMARD(4), .BIT_NUM(4), .CRC_BITS(4), .CRC_POLY(4'h3), .FIFO_DEPTH(4), .CNT_BITS(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          max_lvl  = 0;
    logic [16:0] sb [$];

    // {payload, crc} with CRC hand-computed for x^4+x+1, init 0, MSB first
    logic [19:0] t3_vec [5]  = '{20'h1234C, 20'hA5A5A, 20'h00000, 20'h00035, 20'h00105};
    logic [19:0] t4_vec [10] = '{20'h00013, 20'h00026, 20'h00035, 20'h00105, 20'h0100F,
                                 20'h10002, 20'h80003, 20'hFFFF3, 20'h00FF4, 20'hFF007};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        logic [16:0] e;
        if (!reset) begin
            if (int'(bus.fifo_level) > max_lvl) max_lvl = int'(bus.fifo_level);
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: got %0h expected no output", bus.out_data);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", 32'(bus.out_data), 32'(e[15:0]));
`ifdef RX_ERR_FORWARD_EN
                    chk("out_crc_err", 32'(bus.out_crc_err), 32'(e[16]));
`endif
                end
            end
        end
    end

    task automatic send(input logic [19:0] f, input bit push, input bit flag);
        bit ok = 1'b0;
        bus.in_data  = f;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
        end else if (push) begin
            sb.push_back({flag, f[19:4]});
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || bus.fifo_level != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_in_ready"},   32'(bus.in_ready),   32'd1);
        chk({tag, "_out_valid"},  32'(bus.out_valid),  32'd0);
        chk({tag, "_out_data"},   32'(bus.out_data),   32'd0);
        chk({tag, "_level"},      32'(bus.fifo_level), 32'd0);
        chk({tag, "_frame_cnt"},  32'(bus.frame_cnt),  32'd0);
        chk({tag, "_err_cnt"},    32'(bus.err_cnt),    32'd0);
        chk({tag, "_err_pulse"},  32'(bus.err_pulse),  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_state("reset");

        // single good frame, latency and counters
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send(20'h00013, 1'b1, 1'b0);
        @(negedge clk);
        chk("t1_valid_in_check", 32'(bus.out_valid), 32'd0);
        chk("t1_frame_cnt",      32'(bus.frame_cnt), 32'd1);
        @(negedge clk);
        chk("t1_valid_after",    32'(bus.out_valid), 32'd1);
        chk("t1_err_cnt",        32'(bus.err_cnt),   32'd0);

        // corrupted frame
        @(posedge clk); #1;
        send(20'h00012, FWD, 1'b1);
        @(negedge clk);
        chk("t2_pulse_early", 32'(bus.err_pulse), 32'd0);
        @(negedge clk);
        chk("t2_pulse",       32'(bus.err_pulse), 32'd1);
        chk("t2_err_cnt",     32'(bus.err_cnt),   32'd1);
        chk("t2_frame_cnt",   32'(bus.frame_cnt), 32'd2);
        chk("t2_out_valid",   32'(bus.out_valid), 32'(FWD));
        @(negedge clk);
        chk("t2_pulse_end",   32'(bus.err_pulse), 32'd0);
        drain();

        // backpressure: fill to full, fifth frame parks in S_WAIT
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(t3_vec[i], 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("t3_level_full", 32'(bus.fifo_level), 32'd4);
        chk("t3_in_ready",   32'(bus.in_ready),   32'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("t3_level_popped", 32'(bus.fifo_level), 32'd3);
        chk("t3_still_wait",   32'(bus.in_ready),   32'd0);
        @(negedge clk);
        chk("t3_level_refill", 32'(bus.fifo_level), 32'd4);
        chk("t3_idle_again",   32'(bus.in_ready),   32'd1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        drain();

        // continuous stream, pointers wrap
        max_lvl = 0;
        for (int i = 0; i < 10; i++) send(t4_vec[i], 1'b1, 1'b0);
        drain();
        chk("t4_max_level_le1", 32'(max_lvl <= 1), 32'd1);
        chk("t4_frame_cnt",     32'(bus.frame_cnt), 32'd17);
        chk("t4_err_cnt",       32'(bus.err_cnt),   32'd1);

        // reset while 3 entries queued and a frame is being checked
        bus.out_ready = 1'b0;
        send(20'h00013, 1'b1, 1'b0);
        send(20'h00026, 1'b1, 1'b0);
        send(20'h00035, 1'b1, 1'b0);
        send(20'h80003, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        check_reset_state("midrst");
        bus.out_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_no_output", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        send(20'h1234C, 1'b1, 1'b0);
        drain();
        chk("post_rst_frame_cnt", 32'(bus.frame_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
